wb_axi4l_master_bridge: RTL

- Wishbone classic slave to AXI4-Lite master bridge; the reverse of the AXI-Lite-to-Wishbone bridge that front-ends the on-chip RAM.
- Lets a Wishbone initiator (boot ROM loader, debug/DMA core) reach any AXI-Lite slave on the SoC fabric.
- Single outstanding transaction, fully registered AXI outputs, one clock domain.

---
 rtl/soc_axi_pkg.sv | 18 +
 rtl/wb_axi4l_master_bridge_if.sv | 62 ++++++
 rtl/wb_axi4l_master_bridge.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/soc_axi_pkg.sv
// Shared AXI-Lite definitions for the SoC fabric bridges.
package soc_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    DONE
  } bridge_state_e;

endpackage

// File: rtl/wb_axi4l_master_bridge_if.sv
// Wishbone classic and AXI4-Lite bus bundles used by the bridge.
interface wb_classic_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    cyc_i;
  logic                    stb_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   adr_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH/8-1:0] sel_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    ack_o;
  logic                    err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o
  );
endinterface

interface axi4l_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/wb_axi4l_master_bridge.sv
// Wishbone classic slave to AXI4-Lite master bridge, one transaction
// in flight, every output driven straight from a flop.
module wb_axi4l_master_bridge
  import soc_axi_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] AXI_PROT   = 3'b000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_classic_if.slave wb,
  axi4l_if.master     m_axi
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  bridge_state_e         state;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [DATA_WIDTH-1:0] rdat_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [1:0]            resp_q;
  logic                  abort_q;
  logic                  aw_sent;
  logic                  w_sent;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  ack_q;
  logic                  err_q;

  logic req;
  logic aw_fire;
  logic w_fire;
  logic aw_done;
  logic w_done;

  // The cycle ack/err is visible the FSM is already IDLE; keep the
  // still-asserted strobe from launching a second transaction.
  assign req     = wb.cyc_i & wb.stb_i & ~ack_q & ~err_q;
  assign aw_fire = awvalid_q & m_axi.awready;
  assign w_fire  = wvalid_q & m_axi.wready;
  assign aw_done = aw_sent | aw_fire;
  assign w_done  = w_sent | w_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      rdat_q    <= '0;
      sel_q     <= '0;
      resp_q    <= RESP_OKAY;
      abort_q   <= 1'b0;
      aw_sent   <= 1'b0;
      w_sent    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (state != IDLE && !wb.cyc_i)
        abort_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (req) begin
            adr_q   <= wb.adr_i;
            dat_q   <= wb.dat_i;
            sel_q   <= wb.sel_i;
            abort_q <= 1'b0;
            aw_sent <= 1'b0;
            w_sent  <= 1'b0;
            if (wb.we_i) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state     <= READ;
            end
          end
        end
        WRITE: begin
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_sent   <= 1'b1;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
            w_sent   <= 1'b1;
          end
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: begin
          if (bready_q && m_axi.bvalid) begin
            bready_q <= 1'b0;
            resp_q   <= m_axi.bresp;
            state    <= DONE;
          end
        end
        READ: begin
          if (arvalid_q && m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (rready_q && m_axi.rvalid) begin
            rready_q <= 1'b0;
            rdat_q   <= m_axi.rdata;
            resp_q   <= m_axi.rresp;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!abort_q && wb.cyc_i) begin
            ack_q <= (resp_q == RESP_OKAY);
            err_q <= (resp_q != RESP_OKAY);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axi.awaddr  = adr_q;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = dat_q;
  assign m_axi.wstrb   = sel_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = adr_q;
  assign m_axi.arprot  = AXI_PROT;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign wb.dat_o = rdat_q;
  assign wb.ack_o = ack_q;
  assign wb.err_o = err_q;

endmodule
